// File: rtl/and_gate_sequencer.sv
// Purpose: sequences the 4-vector Gray set (00,01,11,10) through a shared 2-input AND
//          resource ROUNDS times, counting mismatches and reporting pass/done.
// Timing: vector v is checked at edge (v+1)*(SETTLE+1); done pulses one cycle after the last check.
// Backpressure: none; start is sampled only in IDLE and ignored while busy or in DONE.
// Optional build macro AND_SEQ_STOP_ON_FAIL_EN: the first mismatch ends the run immediately.
module and_gate_sequencer #(
    parameter int ROUNDS = 3,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dut_c,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [1:0]       vec_idx
);

    localparam int RND_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int LAST_W = (SETTLE > 0) ? SETTLE - 1 : 0;

    localparam logic [RND_W-1:0]  LAST_RND  = RND_W'(ROUNDS - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(LAST_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // With no settle time a freshly driven vector is checked on the very next edge.
    localparam state_t ARM_ST = (SETTLE == 0) ? CHECK : WAIT;

    state_t            state_q, state_d;
    logic              a_q, a_d;
    logic              b_q, b_d;
    logic [1:0]        idx_q, idx_d;
    logic [RND_W-1:0]  rnd_q, rnd_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pass_q, pass_d;

    logic              mismatch;
    logic              last_vec;
    logic              stop_now;
    logic [1:0]        next_idx;
    logic [CNT_W-1:0]  cnt_chk;

    // Gray order: idx0=00, idx1=01, idx2=11, idx3=10.
    function automatic logic vec_a(input logic [1:0] i);
        return i[1];
    endfunction

    function automatic logic vec_b(input logic [1:0] i);
        return i[1] ^ i[0];
    endfunction

    // Next-state and datapath decode; the mismatch is folded into the count before pass is judged.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        rnd_d    = rnd_q;
        wait_d   = wait_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;

        mismatch = (dut_c != (a_q & b_q));
        last_vec = (idx_q == 2'd3) && (rnd_q == LAST_RND);
        next_idx = idx_q + 2'd1;
        cnt_chk  = cnt_q;
        if (mismatch && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_chk = cnt_q + 1'b1;
        end
`ifdef AND_SEQ_STOP_ON_FAIL_EN
        stop_now = last_vec | mismatch;
`else
        stop_now = last_vec;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = 2'd0;
                    a_d     = vec_a(2'd0);
                    b_d     = vec_b(2'd0);
                    rnd_d   = '0;
                    wait_d  = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    state_d = ARM_ST;
                end
            end
            WAIT: begin
                if (wait_q == LAST_WAIT) begin
                    state_d = CHECK;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            CHECK: begin
                cnt_d = cnt_chk;
                if (stop_now) begin
                    state_d = DONE;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    idx_d   = 2'd0;
                    pass_d  = (cnt_chk == '0);
                end else begin
                    idx_d   = next_idx;
                    a_d     = vec_a(next_idx);
                    b_d     = vec_b(next_idx);
                    wait_d  = '0;
                    state_d = ARM_ST;
                    if (idx_q == 2'd3) begin
                        rnd_d = rnd_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over everything including start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            idx_q   <= 2'd0;
            rnd_q   <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            rnd_q   <= rnd_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign a            = a_q;
    assign b            = b_q;
    assign vec_idx      = idx_q;
    assign mismatch_cnt = cnt_q;
    assign pass         = pass_q;
    assign busy         = (state_q == WAIT) || (state_q == CHECK);
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_and_gate_sequencer.sv
// Bench for and_gate_sequencer: default instance plus a SETTLE=0 / CNT_W=2 instance.
// Stimulus pushes the expected end-of-run record; the monitor pops it on each done pulse.
module tb_and_gate_sequencer;

`ifdef AND_SEQ_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start1 = 1'b0;
    logic start2 = 1'b0;
    int   mode1 = 0;
    int   mode2 = 0;

    logic       a1, b1, busy1, done1, pass1, dut_c1;
    logic [7:0] cnt1;
    logic [1:0] idx1;
    logic       a2, b2, busy2, done2, pass2, dut_c2;
    logic [1:0] cnt2;
    logic [1:0] idx2;

    int tests = 0;
    int fails = 0;
    int edge_no = 0;

    typedef struct {
        int at_edge;
        int cnt;
        int pass;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    // Resource model: 0 = correct AND, 1 = stuck at 0, 2 = OR, 3 = NAND.
    function automatic logic resource(input int m, input logic x, input logic y);
        case (m)
            0:       return x & y;
            1:       return 1'b0;
            2:       return x | y;
            default: return ~(x & y);
        endcase
    endfunction

    assign dut_c1 = resource(mode1, a1, b1);
    assign dut_c2 = resource(mode2, a2, b2);

    and_gate_sequencer u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .start        (start1),
        .dut_c        (dut_c1),
        .a            (a1),
        .b            (b1),
        .busy         (busy1),
        .done         (done1),
        .pass         (pass1),
        .mismatch_cnt (cnt1),
        .vec_idx      (idx1)
    );

    and_gate_sequencer #(.ROUNDS(3), .SETTLE(0), .CNT_W(2)) u_dut2 (
        .clk          (clk),
        .reset        (reset),
        .start        (start2),
        .dut_c        (dut_c2),
        .a            (a2),
        .b            (b2),
        .busy         (busy2),
        .done         (done2),
        .pass         (pass2),
        .mismatch_cnt (cnt2),
        .vec_idx      (idx2)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // Monitor: counts edges and checks each done pulse against the scoreboard.
    always begin
        exp_t e;
        @(posedge clk);
        edge_no = edge_no + 1;
        #1;
        if (done1) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut1_unexpected_done: got done=1 at edge %0d, expected no pulse", edge_no);
            end else begin
                e = q1.pop_front();
                chk("dut1_done_edge", edge_no, e.at_edge);
                chk("dut1_cnt", int'(cnt1), e.cnt);
                chk("dut1_pass", int'(pass1), e.pass);
                chk("dut1_done_ab_idx", int'({a1, b1, idx1}), 0);
                chk("dut1_done_busy", int'(busy1), 0);
            end
        end
        if (done2) begin
            if (q2.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut2_unexpected_done: got done=1 at edge %0d, expected no pulse", edge_no);
            end else begin
                e = q2.pop_front();
                chk("dut2_done_edge", edge_no, e.at_edge);
                chk("dut2_cnt", int'(cnt2), e.cnt);
                chk("dut2_pass", int'(pass2), e.pass);
                chk("dut2_done_ab_idx", int'({a2, b2, idx2}), 0);
            end
        end
    end

    task automatic wait_edge(input int t);
        while (edge_no < t) @(negedge clk);
    endtask

    task automatic run1(input int m, input int len, input int cnt, input int p,
                        input bit do_push, output int e0);
        @(negedge clk);
        mode1  = m;
        start1 = 1'b1;
        e0     = edge_no + 1;
        if (do_push) q1.push_back('{e0 + len, cnt, p});
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic run2(input int m, input int len, input int cnt, input int p, output int e0);
        @(negedge clk);
        mode2  = m;
        start2 = 1'b1;
        e0     = edge_no + 1;
        q2.push_back('{e0 + len, cnt, p});
        @(negedge clk);
        start2 = 1'b0;
    endtask

    initial begin
        int e0;
        logic [1:0] exp_ab [4];
        exp_ab[0] = 2'b00;
        exp_ab[1] = 2'b01;
        exp_ab[2] = 2'b11;
        exp_ab[3] = 2'b10;

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        chk("rst_dut1_outs", int'({a1, b1, busy1, done1, pass1, idx1}), 0);
        chk("rst_dut1_cnt", int'(cnt1), 0);
        chk("rst_dut2_outs", int'({a2, b2, busy2, done2, pass2, idx2, cnt2}), 0);
        reset = 1'b0;

        // Correct resource: walk the Gray sequence and expect a clean pass at edge 24.
        run1(0, 24, 0, 1, 1'b1, e0);
        for (int k = 0; k <= 4; k++) begin
            wait_edge(e0 + 2 * k);
            chk("seq_idx", int'(idx1), k % 4);
            chk("seq_ab", int'({a1, b1}), int'(exp_ab[k % 4]));
            chk("seq_busy", int'(busy1), 1);
        end
        wait_edge(e0 + 26);

        // Stuck-at-0 resource: only idx2 of each round mismatches.
        run1(1, STOP ? 6 : 24, STOP ? 1 : 3, 0, 1'b1, e0);
        wait_edge(e0 + 26);

        // OR resource: idx1 and idx3 mismatch; results must hold while idle.
        run1(2, STOP ? 4 : 24, STOP ? 1 : 6, 0, 1'b1, e0);
        wait_edge(e0 + 30);
        chk("hold_cnt", int'(cnt1), STOP ? 1 : 6);
        chk("hold_pass", int'(pass1), 0);
        chk("idle_ab_idx", int'({a1, b1, idx1, busy1}), 0);

        // NAND resource: every vector mismatches.
        run1(3, STOP ? 2 : 24, STOP ? 1 : 12, 0, 1'b1, e0);
        wait_edge(e0 + 26);

        // A start pulse mid-run is ignored; one done pulse still follows edge 24.
        run1(0, 24, 0, 1, 1'b1, e0);
        wait_edge(e0 + 4);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("restart_ignored_busy", int'(busy1), 1);
        chk("restart_ignored_idx", int'(idx1), 2);
        wait_edge(e0 + 30);

        // Start held high: a second run begins on the first IDLE cycle after DONE.
        @(negedge clk);
        mode1  = 0;
        start1 = 1'b1;
        e0     = edge_no + 1;
        q1.push_back('{e0 + 24, 0, 1});
        q1.push_back('{e0 + 50, 0, 1});
        wait_edge(e0 + 26);
        start1 = 1'b0;
        chk("held_start_busy", int'(busy1), 1);
        wait_edge(e0 + 52);

        // Reset asserted at edge 9 of a failing run: back to IDLE with counters cleared.
        run1(1, 6, 1, 0, STOP, e0);
        wait_edge(e0 + 8);
        chk("pre_rst_cnt", int'(cnt1), 1);
        reset = 1'b1;
        wait_edge(e0 + 9);
        chk("mid_rst_outs", int'({a1, b1, busy1, done1, pass1, idx1}), 0);
        chk("mid_rst_cnt", int'(cnt1), 0);
        reset = 1'b0;
        wait_edge(e0 + 40);
        chk("post_rst_cnt", int'(cnt1), 0);

        // SETTLE=0, CNT_W=2: NAND saturates at 3; then a clean run at edge 12.
        run2(3, STOP ? 1 : 12, STOP ? 1 : 3, 0, e0);
        wait_edge(e0 + 14);
        run2(0, 12, 0, 1, e0);
        wait_edge(e0 + 14);

        for (int i = 0; i < 200 && (q1.size() + q2.size()) > 0; i++) @(negedge clk);
        chk("scoreboard_drained", q1.size() + q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/and_gate_sequencer.md
AND_GATE_SEQUENCER -- requirements
Module: and_gate_sequencer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with every state change occurring on the rising edge of clk.
REQ-002 Parameter ROUNDS, default 3: number of full passes over the 4-vector set (>=1).
REQ-003 Parameter SETTLE, default 1: wait cycles between driving a vector and sampling the result (>=0).
REQ-004 Parameter CNT_W, default 8: width of mismatch_cnt.
REQ-005 clk  input  1  clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  begin a run; sampled only in IDLE.
REQ-008 dut_c  input  1  result from the shared 2-input AND resource.
REQ-009 a  output  1  operand A driven to the resource (registered).
REQ-010 b  output  1  operand B driven to the resource (registered).
REQ-011 busy  output  1  high in WAIT and CHECK.
REQ-012 done  output  1  one-cycle pulse at end of run.
REQ-013 pass  output  1  1 when the last completed run had zero mismatches.
REQ-014 mismatch_cnt  output  CNT_W  mismatches in the current/last run, saturating.
REQ-015 vec_idx  output  2  index of the vector currently driven.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, CHECK and DONE.
REQ-017 Vector order SHALL be the Gray sequence idx0=(a0,b0), idx1=(0,1), idx2=(1,1), idx3=(1,0), repeated ROUNDS times.
REQ-018 IDLE with start=1 at edge 0 SHALL load vector idx0 on a/b, clear mismatch_cnt and pass, and go to WAIT (or to CHECK if SETTLE=0).
REQ-019 WAIT SHALL last exactly SETTLE cycles and then go to CHECK.
REQ-020 On the CHECK edge the block SHALL compare dut_c with (a&b) and increment mismatch_cnt on inequality, saturating at 2^CNT_W-1.
REQ-021 On the same CHECK edge the block SHALL load the next vector (wrapping idx3->idx0 and incrementing the round count) and go to WAIT/CHECK, or go to DONE after the last vector of the last round.
REQ-022 Vector v (0-based over the run) SHALL be checked at edge (v+1)*(SETTLE+1); DONE SHALL be entered after edge 4*ROUNDS*(SETTLE+1).
REQ-023 DONE SHALL last one cycle with done=1, SHALL set pass=(final mismatch_cnt==0), and SHALL return to IDLE.
REQ-024 In IDLE and DONE, a/b SHALL be driven 0,0 and vec_idx SHALL be 0.
REQ-025 pass and mismatch_cnt SHALL hold their values until the next accepted start.
REQ-026 start while busy or in DONE SHALL be ignored; start held high SHALL launch a new run on the first IDLE cycle.
REQ-027 If the mismatch and the final vector occur in the same CHECK cycle, the mismatch SHALL be counted before pass is evaluated.

Reset
REQ-028 reset=1 SHALL force IDLE from any state, including mid-run, on the next edge, and SHALL clear the counters.
REQ-029 Reset values SHALL be a=0, b=0, busy=0, done=0, pass=0, mismatch_cnt=0, vec_idx=0.
REQ-030 reset SHALL have priority over start.

Configuration
REQ-031 When macro AND_SEQ_STOP_ON_FAIL_EN is defined, the first mismatch in CHECK SHALL send the FSM directly to DONE, with mismatch_cnt=1 and pass=0.
REQ-032 When AND_SEQ_STOP_ON_FAIL_EN is undefined, all 4*ROUNDS vectors SHALL always be run.

Verification
REQ-033 Defaults with dut_c=a&b: start at edge 0 -> done=1 in the cycle after edge 24, mismatch_cnt=0, pass=1.
REQ-034 Defaults with dut_c tied to 0: mismatch_cnt=3 (idx2 in each round), pass=0.
REQ-035 Defaults with dut_c=a|b and the macro undefined: mismatch_cnt=6; with the macro defined: done after edge 4, mismatch_cnt=1.
REQ-036 CNT_W=2 with dut_c=~(a&b): 12 raw mismatches -> mismatch_cnt=3 (saturated).
REQ-037 Reset asserted at edge 9 of a run: IDLE, a=b=0, mismatch_cnt=0, no done pulse.
REQ-038 start pulsed at edge 5 of a run: ignored; the single done pulse still follows edge 24.
